cisc_control: RTL and testbench

- Instruction sequencer for the SimpleCISC CPU. It sits on the control side of the datapath.
- It consumes IR and ZReg from the datapath and produces every datapath control strobe (Function, UpdateZ, Enable*/Load*, IncPC, SelPC, LoadIR, LoadMAR, EnableReg), plus the memory read/write strobes.
- It implements a multi-cycle fetch/decode/address/execute machine for a one-accumulator, two-word-instruction ISA.

---
 rtl/cisc_control_pkg.sv | 41 ++++
 rtl/cisc_control.sv | 188 ++++++++++++++++++
 tb/tb_cisc_control.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cisc_control_pkg.sv
// Shared encodings for the SimpleCISC control path and ALU: opcodes, ALU functions, sequencer states.
// Pure type/constant package; no latency or backpressure of its own.
package cisc_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_JMP   = 4'h7,
        OP_JZ    = 4'h8,
        OP_JNZ   = 4'h9,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        FN_PASSB = 4'd0,
        FN_PASSA = 4'd1,
        FN_ADD   = 4'd2,
        FN_SUB   = 4'd3,
        FN_AND   = 4'd4,
        FN_OR    = 4'd5
    } alu_fn_t;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ADDR   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] REG_ACC = 2'b00;
    localparam logic [1:0] REG_X   = 2'b01;
    localparam logic [1:0] REG_S   = 2'b10;

endpackage

// File: rtl/cisc_control.sv
// Multi-cycle fetch/decode/address/execute sequencer; outputs are combinational decodes of state/IR/ZReg (NOP 2, jump 3, mem op 4 cycles).
// With CISC_CTRL_WAIT_EN, Ready=0 stalls memory steps and suppresses all register/PC updates until Ready=1.
module cisc_control
    import cisc_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] IR,
    input  logic        ZReg,
`ifdef CISC_CTRL_WAIT_EN
    input  logic        Ready,
`endif
    output logic [3:0]  Function,
    output logic        UpdateZ,
    output logic        EnableACC,
    output logic        EnableX,
    output logic        EnableS,
    output logic        EnablePC,
    output logic        LoadACC,
    output logic        LoadX,
    output logic        LoadS,
    output logic        LoadPC,
    output logic        IncPC,
    output logic        SelPC,
    output logic        LoadIR,
    output logic        LoadMAR,
    output logic        EnableReg,
    output logic        RdMem,
    output logic        WrMem
);

    localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_rst_cnt;
    logic [3:0] w_cnt_nxt;
    alu_fn_t    w_fn;
    opcode_t    w_op;
    logic       w_ready;
    logic       w_mem_step;
    logic       w_is_jump;
    logic       w_take;
    logic       w_en_sel;
    logic       w_ld_sel;
    logic       w_unused_ir;

`ifdef CISC_CTRL_WAIT_EN
    assign w_ready = Ready;
`else
    assign w_ready = 1'b1;
`endif

    assign w_op        = opcode_t'(IR[15:12]);
    assign w_unused_ir = ^IR[8:0];
    assign w_is_jump   = (w_op == OP_JMP) || (w_op == OP_JZ) || (w_op == OP_JNZ);
    assign w_take      = (w_op == OP_JMP) || ((w_op == OP_JZ) && ZReg) || ((w_op == OP_JNZ) && !ZReg);
    assign Function    = w_fn;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_RESET;
            r_rst_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_rst_cnt;
        w_fn        = FN_PASSB;
        w_mem_step  = 1'b0;
        w_en_sel    = 1'b0;
        w_ld_sel    = 1'b0;
        {UpdateZ, EnableACC, EnableX, EnableS, EnablePC, LoadACC, LoadX, LoadS, LoadPC,
         IncPC, SelPC, LoadIR, LoadMAR, EnableReg, RdMem, WrMem} = '0;

        case (r_state)
            ST_RESET: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_rst_cnt + 4'd1;
                end
            end
            ST_FETCH: begin
                SelPC       = 1'b1;
                RdMem       = 1'b1;
                LoadIR      = 1'b1;
                IncPC       = 1'b1;
                w_mem_step  = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_JMP, OP_JZ, OP_JNZ: w_state_nxt = ST_ADDR;
                    OP_HALT:               w_state_nxt = ST_HALT;
                    default:               w_state_nxt = ST_FETCH;
                endcase
            end
            ST_ADDR: begin
                SelPC      = 1'b1;
                RdMem      = 1'b1;
                w_mem_step = 1'b1;
                if (IR[11]) begin
                    w_fn    = FN_ADD;
                    EnableX = 1'b1;
                end
                // A jump not taken still has to step PC over its operand word.
                if (w_is_jump) begin
                    LoadPC      = w_take;
                    IncPC       = !w_take;
                    w_state_nxt = ST_FETCH;
                end else begin
                    LoadMAR     = 1'b1;
                    IncPC       = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_mem_step  = 1'b1;
                w_state_nxt = ST_FETCH;
                case (w_op)
                    OP_LOAD: begin
                        RdMem    = 1'b1;
                        w_ld_sel = 1'b1;
                        UpdateZ  = 1'b1;
                    end
                    OP_STORE: begin
                        w_en_sel  = 1'b1;
                        EnableReg = 1'b1;
                        WrMem     = 1'b1;
                        w_fn      = FN_PASSA;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        RdMem    = 1'b1;
                        w_en_sel = 1'b1;
                        w_ld_sel = 1'b1;
                        UpdateZ  = 1'b1;
                        case (w_op)
                            OP_SUB:  w_fn = FN_SUB;
                            OP_AND:  w_fn = FN_AND;
                            OP_OR:   w_fn = FN_OR;
                            default: w_fn = FN_ADD;
                        endcase
                    end
                    default: ;
                endcase
                case (IR[10:9])
                    REG_X: begin
                        EnableX = w_en_sel;
                        LoadX   = w_ld_sel;
                    end
                    REG_S: begin
                        EnableS = w_en_sel;
                        LoadS   = w_ld_sel;
                    end
                    default: begin
                        EnableACC = w_en_sel;
                        LoadACC   = w_ld_sel;
                    end
                endcase
            end
            ST_HALT: SelPC = 1'b1;
            default: w_state_nxt = ST_RESET;
        endcase

        // Memory not ready: keep the bus cycle up but commit nothing.
        if (w_mem_step && !w_ready) begin
            w_state_nxt = r_state;
            LoadACC     = 1'b0;
            LoadX       = 1'b0;
            LoadS       = 1'b0;
            LoadPC      = 1'b0;
            LoadIR      = 1'b0;
            LoadMAR     = 1'b0;
            IncPC       = 1'b0;
            UpdateZ     = 1'b0;
        end
    end

endmodule

// File: tb/tb_cisc_control.sv
// Directed bench for cisc_control: per-cycle strobe vectors compared against hand-derived values.
module tb_cisc_control;
    import cisc_pkg::*;

    localparam logic [15:0] M_WR   = 16'h0001;
    localparam logic [15:0] M_RD   = 16'h0002;
    localparam logic [15:0] M_ER   = 16'h0004;
    localparam logic [15:0] M_LMAR = 16'h0008;
    localparam logic [15:0] M_LIR  = 16'h0010;
    localparam logic [15:0] M_SEL  = 16'h0020;
    localparam logic [15:0] M_INC  = 16'h0040;
    localparam logic [15:0] M_LPC  = 16'h0080;
    localparam logic [15:0] M_LS   = 16'h0100;
    localparam logic [15:0] M_LX   = 16'h0200;
    localparam logic [15:0] M_LACC = 16'h0400;
    localparam logic [15:0] M_EPC  = 16'h0800;
    localparam logic [15:0] M_ES   = 16'h1000;
    localparam logic [15:0] M_EX   = 16'h2000;
    localparam logic [15:0] M_EACC = 16'h4000;
    localparam logic [15:0] M_UZ   = 16'h8000;

    logic        Clock;
    logic        nReset;
    logic [15:0] IR;
    logic        ZReg;
`ifdef CISC_CTRL_WAIT_EN
    logic        Ready;
`endif
    logic [3:0]  Function;
    logic        UpdateZ, EnableACC, EnableX, EnableS, EnablePC;
    logic        LoadACC, LoadX, LoadS, LoadPC;
    logic        IncPC, SelPC, LoadIR, LoadMAR, EnableReg, RdMem, WrMem;
    logic [19:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    cisc_control #(.RESET_CYCLES(1)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .IR        (IR),
        .ZReg      (ZReg),
`ifdef CISC_CTRL_WAIT_EN
        .Ready     (Ready),
`endif
        .Function  (Function),
        .UpdateZ   (UpdateZ),
        .EnableACC (EnableACC),
        .EnableX   (EnableX),
        .EnableS   (EnableS),
        .EnablePC  (EnablePC),
        .LoadACC   (LoadACC),
        .LoadX     (LoadX),
        .LoadS     (LoadS),
        .LoadPC    (LoadPC),
        .IncPC     (IncPC),
        .SelPC     (SelPC),
        .LoadIR    (LoadIR),
        .LoadMAR   (LoadMAR),
        .EnableReg (EnableReg),
        .RdMem     (RdMem),
        .WrMem     (WrMem)
    );

    assign obs = {Function, UpdateZ, EnableACC, EnableX, EnableS, EnablePC, LoadACC, LoadX,
                  LoadS, LoadPC, IncPC, SelPC, LoadIR, LoadMAR, EnableReg, RdMem, WrMem};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [19:0] ex(input logic [3:0] fn, input logic [15:0] m);
        return {fn, m};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Advance to the middle of the next cycle and compare the strobe vector.
    task automatic nxt(input string tag, input logic [19:0] exp);
        @(negedge Clock);
        #1;
        chk(tag, obs, exp);
    endtask

    logic [19:0] f_fetch;

    initial begin
        f_fetch = ex(FN_PASSB, M_SEL | M_RD | M_LIR | M_INC);
        nReset  = 1'b0;
        IR      = 16'h0000;
        ZReg    = 1'b0;
`ifdef CISC_CTRL_WAIT_EN
        Ready   = 1'b1;
`endif
        repeat (2) @(negedge Clock);
        #1;
        chk("rst_out", obs, 20'h0);
        nReset = 1'b1;
        #1;
        chk("rst_cycle", obs, 20'h0);
        nxt("fetch_first", f_fetch);

        // LOAD ACC, direct
        IR = 16'h1000;
        nxt("ld_dec", 20'h0);
        nxt("ld_addr", ex(FN_PASSB, M_SEL | M_RD | M_LMAR | M_INC));
        nxt("ld_exec", ex(FN_PASSB, M_RD | M_LACC | M_UZ));
        nxt("ld_refetch", f_fetch);

        // STORE X, indexed
        IR = 16'h2A00;
        nxt("st_dec", 20'h0);
        nxt("st_addr", ex(FN_ADD, M_EX | M_SEL | M_RD | M_LMAR | M_INC));
        nxt("st_exec", ex(FN_PASSA, M_EX | M_ER | M_WR));
        nxt("st_refetch", f_fetch);

        // JZ taken
        IR = 16'h8000;
        ZReg = 1'b1;
        nxt("jz_t_dec", 20'h0);
        nxt("jz_t_addr", ex(FN_PASSB, M_SEL | M_RD | M_LPC));
        nxt("jz_t_refetch", f_fetch);

        // JZ not taken
        ZReg = 1'b0;
        nxt("jz_n_dec", 20'h0);
        nxt("jz_n_addr", ex(FN_PASSB, M_SEL | M_RD | M_INC));
        nxt("jz_n_refetch", f_fetch);

        // JNZ indexed, taken with ZReg=0
        IR = 16'h9800;
        nxt("jnz_dec", 20'h0);
        nxt("jnz_addr", ex(FN_ADD, M_EX | M_SEL | M_RD | M_LPC));
        nxt("jnz_refetch", f_fetch);

        // NOP and undefined opcode: two-cycle round trip
        IR = 16'h0000;
        nxt("nop_dec", 20'h0);
        nxt("nop_refetch", f_fetch);
        IR = 16'hB000;
        nxt("undef_dec", 20'h0);
        nxt("undef_refetch", f_fetch);

        // SUB S, direct
        IR = 16'h4400;
        nxt("sub_dec", 20'h0);
        nxt("sub_addr", ex(FN_PASSB, M_SEL | M_RD | M_LMAR | M_INC));
        nxt("sub_exec", ex(FN_SUB, M_RD | M_ES | M_LS | M_UZ));
        nxt("sub_refetch", f_fetch);

        // OR with reg select 11 maps to ACC
        IR = 16'h6600;
        nxt("or_dec", 20'h0);
        nxt("or_addr", ex(FN_PASSB, M_SEL | M_RD | M_LMAR | M_INC));
        nxt("or_exec", ex(FN_OR, M_RD | M_EACC | M_LACC | M_UZ));
        nxt("or_refetch", f_fetch);

`ifdef CISC_CTRL_WAIT_EN
        // ADD ACC with three wait cycles in EXEC
        IR = 16'h3000;
        nxt("wt_dec", 20'h0);
        nxt("wt_addr", ex(FN_PASSB, M_SEL | M_RD | M_LMAR | M_INC));
        @(posedge Clock);
        #1;
        Ready = 1'b0;
        for (int i = 0; i < 3; i++) nxt("wt_stall", ex(FN_ADD, M_RD | M_EACC));
        @(negedge Clock);
        #1;
        Ready = 1'b1;
        #1;
        chk("wt_done", obs, ex(FN_ADD, M_RD | M_EACC | M_LACC | M_UZ));
        nxt("wt_refetch", f_fetch);
`endif

        // Reset asserted during STORE execute aborts at once
        IR = 16'h2000;
        nxt("ab_dec", 20'h0);
        nxt("ab_addr", ex(FN_PASSB, M_SEL | M_RD | M_LMAR | M_INC));
        nxt("ab_exec", ex(FN_PASSA, M_EACC | M_ER | M_WR));
        nReset = 1'b0;
        #1;
        chk("ab_abort", obs, 20'h0);
        @(negedge Clock);
        #1;
        nReset = 1'b1;
        nxt("ab_refetch", f_fetch);

        // HALT is terminal until reset
        IR = 16'hF000;
        nxt("halt_dec", 20'h0);
        for (int i = 0; i < 20; i++) nxt("halt_hold", ex(FN_PASSB, M_SEL));
        nReset = 1'b0;
        #1;
        chk("halt_rst", obs, 20'h0);
        @(negedge Clock);
        #1;
        nReset = 1'b1;
        #1;
        chk("halt_rst_cycle", obs, 20'h0);
        nxt("halt_refetch", f_fetch);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
